uart_tx: RTL

//  8N1 UART transmitter: the sending end of the bot's serial link to the

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake into a small FIFO, then LSB-first
// serialisation onto a registered tx line with back-to-back frames when data is queued.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               baud_last;
    logic [7:0]         head;

    assign tx_ready   = (count_q != CNT_FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (count_q == '0);
    assign baud_last  = (baud_q == BAUD_LAST);
    assign head       = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // FIFO bookkeeping; a pop frees the head slot on the same edge
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Frame sequencer; tx/busy are derived from the next state so they stay aligned with it
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end

endmodule
